cpu_tiny: RTL and testbench

`cpu_tiny` is an 8-bit accumulator processor with its own unified program/data memory. After reset it executes a program preloaded into its memory array, one fixed-length two-byte instruction per three clocks. It runs until it halts. It is the top of the tiny-CPU design; the memory image before and after a run is the primary verification artifact.

---
 rtl/cpu_tiny_pkg.sv | 28 ++
 rtl/cpu_tiny_core.sv | 125 ++++++++++++
 rtl/cpu_tiny_mem.sv | 27 ++
 rtl/cpu_tiny.sv | 46 ++++
 tb/tb_cpu_tiny.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_tiny_pkg.sv
// Shared constants for the tiny accumulator CPU: default widths, opcodes and FSM states.
package cpu_tiny_pkg;

    localparam int unsigned ADDR_W_DEF = 8;
    localparam int unsigned DATA_W_DEF = 8;

    localparam logic [7:0] OP_NOP = 8'h00;
    localparam logic [7:0] OP_LDA = 8'h01;
    localparam logic [7:0] OP_STA = 8'h02;
    localparam logic [7:0] OP_ADD = 8'h03;
    localparam logic [7:0] OP_SUB = 8'h04;
    localparam logic [7:0] OP_AND = 8'h05;
    localparam logic [7:0] OP_OR  = 8'h06;
    localparam logic [7:0] OP_XOR = 8'h07;
    localparam logic [7:0] OP_LDI = 8'h08;
    localparam logic [7:0] OP_JMP = 8'h09;
    localparam logic [7:0] OP_JZ  = 8'h0A;
    localparam logic [7:0] OP_JC  = 8'h0B;
    localparam logic [7:0] OP_HLT = 8'h0F;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        OPER  = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } state_t;

endpackage

// File: rtl/cpu_tiny_core.sv
// Fetch/operand/execute sequencer with pc, accumulator, carry flag and ALU.
module cpu_tiny_core
    import cpu_tiny_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_W_DEF,
    parameter int unsigned DATA_WIDTH = DATA_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  write,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] wdata,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [DATA_WIDTH-1:0] acc,
    output logic                  halted
);

    state_t                state, state_n;
    logic [ADDR_WIDTH-1:0] pc_n;
    logic [DATA_WIDTH-1:0] acc_n;
    logic [DATA_WIDTH-1:0] ir, ir_n;
    logic [DATA_WIDTH-1:0] operand, operand_n;
    logic                  c_flag, c_flag_n;
    logic                  halted_n;
    logic [DATA_WIDTH:0]   sum;
    logic [DATA_WIDTH:0]   diff;
    logic [ADDR_WIDTH-1:0] op_addr;
    logic                  zero;

    assign op_addr = ADDR_WIDTH'(operand);
    assign zero    = (acc == '0);
    assign sum     = {1'b0, acc} + {1'b0, rdata};
    // Top bit of the widened difference is the borrow.
    assign diff    = {1'b0, acc} - {1'b0, rdata};
    assign wdata   = acc;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= FETCH;
            pc      <= '0;
            acc     <= '0;
            ir      <= '0;
            operand <= '0;
            c_flag  <= 1'b0;
            halted  <= 1'b0;
        end else begin
            state   <= state_n;
            pc      <= pc_n;
            acc     <= acc_n;
            ir      <= ir_n;
            operand <= operand_n;
            c_flag  <= c_flag_n;
            halted  <= halted_n;
        end
    end

    always_comb begin
        state_n   = state;
        pc_n      = pc;
        acc_n     = acc;
        ir_n      = ir;
        operand_n = operand;
        c_flag_n  = c_flag;
        halted_n  = halted;
        addr      = pc;
        write     = 1'b0;

        case (state)
            FETCH: begin
                addr    = pc;
                ir_n    = rdata;
                state_n = OPER;
            end
            OPER: begin
                addr      = pc + ADDR_WIDTH'(1);
                operand_n = rdata;
                state_n   = EXEC;
            end
            EXEC: begin
                addr    = op_addr;
                pc_n    = pc + ADDR_WIDTH'(2);
                state_n = FETCH;
                case (ir)
                    DATA_WIDTH'(OP_LDA): acc_n = rdata;
                    DATA_WIDTH'(OP_STA): write = 1'b1;
                    DATA_WIDTH'(OP_ADD): begin
                        acc_n    = sum[DATA_WIDTH-1:0];
                        c_flag_n = sum[DATA_WIDTH];
                    end
                    DATA_WIDTH'(OP_SUB): begin
                        acc_n    = diff[DATA_WIDTH-1:0];
                        c_flag_n = diff[DATA_WIDTH];
                    end
                    DATA_WIDTH'(OP_AND): acc_n = acc & rdata;
                    DATA_WIDTH'(OP_OR):  acc_n = acc | rdata;
                    DATA_WIDTH'(OP_XOR): acc_n = acc ^ rdata;
                    DATA_WIDTH'(OP_LDI): acc_n = operand;
                    DATA_WIDTH'(OP_JMP): pc_n = op_addr;
                    DATA_WIDTH'(OP_JZ):  if (zero) pc_n = op_addr;
                    DATA_WIDTH'(OP_JC):  if (c_flag) pc_n = op_addr;
                    DATA_WIDTH'(OP_HLT): begin
                        pc_n     = pc;
                        halted_n = 1'b1;
                        state_n  = HALT;
                    end
                    default: ;
                endcase
            end
            HALT: begin
                addr = pc;
            end
            default: begin
                state_n = FETCH;
            end
        endcase

        // Reset abandons the instruction in flight, including any pending store.
        if (!rst) begin
            write = 1'b0;
            addr  = '0;
        end
    end

endmodule

// File: rtl/cpu_tiny_mem.sv
// Unified program/data memory: combinational read, rising-edge write, no reset.
module cpu_tiny_mem
    import cpu_tiny_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_W_DEF,
    parameter int unsigned DATA_WIDTH = DATA_W_DEF
) (
    input  logic                  clk,
    input  logic                  write,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (write) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/cpu_tiny.sv
// Tiny accumulator CPU top: connects the core to its unified memory.
module cpu_tiny
    import cpu_tiny_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_W_DEF,
    parameter int unsigned DATA_WIDTH = DATA_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  halted,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [DATA_WIDTH-1:0] acc,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata
);

    logic [DATA_WIDTH-1:0] mem_rdata;

    cpu_tiny_core #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) cpu_inst (
        .clk   (clk),
        .rst   (rst),
        .write (mem_write),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (mem_rdata),
        .pc    (pc),
        .acc   (acc),
        .halted(halted)
    );

    cpu_tiny_mem #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) memory_inst (
        .clk  (clk),
        .write(mem_write),
        .addr (mem_addr),
        .wdata(mem_wdata),
        .rdata(mem_rdata)
    );

endmodule

// File: tb/tb_cpu_tiny.sv
// Self-checking bench for cpu_tiny: directed programs plus random programs against an ISA-level model.
module tb_cpu_tiny;

    logic       clk;
    logic       rst;
    logic       halted;
    logic [7:0] pc;
    logic [7:0] acc;
    logic       mem_write;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;

    int total = 0;
    int bad   = 0;

    // Instruction-level reference model state
    logic [7:0] m_mem [256];
    int         m_pc;
    int         m_acc;
    int         m_c;
    int         m_halt;

    cpu_tiny dut (
        .clk      (clk),
        .rst      (rst),
        .halted   (halted),
        .pc       (pc),
        .acc      (acc),
        .mem_write(mem_write),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 0; m_acc = 0; m_c = 0; m_halt = 0;
    endtask

    // Execute one instruction according to the ISA rules.
    task automatic model_step();
        int op, arg, b, r, nxt;
        if (m_halt != 0) return;
        op  = int'(m_mem[m_pc]);
        arg = int'(m_mem[(m_pc + 1) % 256]);
        b   = int'(m_mem[arg]);
        nxt = (m_pc + 2) % 256;
        case (op)
            1:  m_acc = b;
            2:  m_mem[arg] = 8'(m_acc);
            3:  begin r = m_acc + b; m_c = (r > 255) ? 1 : 0; m_acc = r % 256; end
            4:  begin r = m_acc - b; m_c = (r < 0) ? 1 : 0; m_acc = (r + 256) % 256; end
            5:  m_acc = m_acc & b;
            6:  m_acc = m_acc | b;
            7:  m_acc = m_acc ^ b;
            8:  m_acc = arg;
            9:  nxt = arg;
            10: if (m_acc == 0) nxt = arg;
            11: if (m_c != 0) nxt = arg;
            15: begin m_halt = 1; nxt = m_pc; end
            default: ;
        endcase
        m_pc = nxt;
    endtask

    task automatic fill_bg();
        for (int i = 0; i < 256; i++) m_mem[i] = 8'($urandom);
    endtask

    task automatic load_image();
        for (int i = 0; i < 256; i++) dut.memory_inst.mem[i] <= m_mem[i];
    endtask

    // Hold reset two edges while loading the image, release at a falling edge.
    task automatic prepare();
        @(negedge clk);
        rst = 1'b0;
        load_image();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    task automatic check_step(input string tag);
        check({tag, ".pc"},     32'(pc),        32'(m_pc));
        check({tag, ".acc"},    32'(acc),       32'(m_acc));
        check({tag, ".halted"}, 32'(halted),    32'(m_halt));
        check({tag, ".c"},      32'(dut.cpu_inst.c_flag), 32'(m_c));
        check({tag, ".addr"},   32'(mem_addr),  32'(m_pc));
        check({tag, ".write"},  32'(mem_write), 32'(0));
        check({tag, ".wdata"},  32'(mem_wdata), 32'(m_acc));
    endtask

    task automatic run_instr(input string tag);
        repeat (3) @(posedge clk);
        #1;
        model_step();
        check_step(tag);
    endtask

    task automatic check_mem(input string tag);
        for (int i = 0; i < 256; i++)
            check($sformatf("%s.mem[%02h]", tag, i), 32'(dut.memory_inst.mem[i]), 32'(m_mem[i]));
    endtask

    initial begin
        int cycles;
        int r;
        rst = 1'b0;

        // Reset with arbitrary memory contents
        fill_bg();
        load_image();
        repeat (2) @(posedge clk);
        #1;
        check("reset.pc", 32'(pc), 32'h0);
        check("reset.acc", 32'(acc), 32'h0);
        check("reset.halted", 32'(halted), 32'h0);
        check("reset.write", 32'(mem_write), 32'h0);
        check("reset.addr", 32'(mem_addr), 32'h0);
        check_mem("reset");

        // Load / add / store
        fill_bg();
        m_mem[0] = 8'h01; m_mem[1] = 8'h10; m_mem[2] = 8'h03; m_mem[3] = 8'h11;
        m_mem[4] = 8'h02; m_mem[5] = 8'h12; m_mem[6] = 8'h0F; m_mem[7] = 8'h00;
        m_mem[8'h10] = 8'h05; m_mem[8'h11] = 8'h07;
        prepare();
        for (int k = 0; k < 3; k++) run_instr($sformatf("las.i%0d", k));
        check("las.store", 32'(dut.memory_inst.mem[8'h12]), 32'h0C);
        run_instr("las.i3");
        check("las.halted", 32'(halted), 32'h1);
        run_instr("las.absorb0");
        run_instr("las.absorb1");
        check_mem("las");

        // Carry set: jump taken to HLT at 0x10
        fill_bg();
        m_mem[0] = 8'h08; m_mem[1] = 8'hFF; m_mem[2] = 8'h03; m_mem[3] = 8'h20;
        m_mem[4] = 8'h0B; m_mem[5] = 8'h10; m_mem[6] = 8'h0F; m_mem[8'h10] = 8'h0F;
        m_mem[8'h20] = 8'h01;
        prepare();
        for (int k = 0; k < 4; k++) run_instr($sformatf("carry1.i%0d", k));
        check("carry1.acc", 32'(acc), 32'h00);
        check("carry1.c", 32'(dut.cpu_inst.c_flag), 32'h1);
        check("carry1.pc", 32'(pc), 32'h10);
        check("carry1.halted", 32'(halted), 32'h1);

        // Carry clear: falls through to HLT at 0x06
        m_mem[8'h20] = 8'h00;
        prepare();
        for (int k = 0; k < 4; k++) run_instr($sformatf("carry0.i%0d", k));
        check("carry0.acc", 32'(acc), 32'hFF);
        check("carry0.c", 32'(dut.cpu_inst.c_flag), 32'h0);
        check("carry0.pc", 32'(pc), 32'h06);
        check_mem("carry");

        // Countdown loop: 11 instructions, 33 cycles to halt
        fill_bg();
        m_mem[0]  = 8'h08; m_mem[1]  = 8'h03;
        m_mem[2]  = 8'h04; m_mem[3]  = 8'h30;
        m_mem[4]  = 8'h0A; m_mem[5]  = 8'h0A;
        m_mem[6]  = 8'h09; m_mem[7]  = 8'h02;
        m_mem[10] = 8'h02; m_mem[11] = 8'h31;
        m_mem[12] = 8'h0F;
        m_mem[8'h30] = 8'h01; m_mem[8'h31] = 8'h55;
        prepare();
        cycles = 0;
        while (halted !== 1'b1 && cycles < 200) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        check("loop.cycles", 32'(cycles), 32'd33);
        check("loop.stored", 32'(dut.memory_inst.mem[8'h31]), 32'h00);
        for (int k = 0; k < 100 && m_halt == 0; k++) model_step();
        check_step("loop.final");
        check_mem("loop");

        // Reset during EXEC of a STA
        fill_bg();
        m_mem[0] = 8'h08; m_mem[1] = 8'h77; m_mem[2] = 8'h02; m_mem[3] = 8'h40;
        m_mem[4] = 8'h0F; m_mem[8'h40] = 8'h11;
        prepare();
        run_instr("rmid.ldi");
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rmid.strobe", 32'(mem_write), 32'h1);
        check("rmid.staddr", 32'(mem_addr), 32'h40);
        rst = 1'b0;
        #1;
        check("rmid.gated", 32'(mem_write), 32'h0);
        @(posedge clk);
        #1;
        check("rmid.target", 32'(dut.memory_inst.mem[8'h40]), 32'h11);
        check("rmid.pc", 32'(pc), 32'h0);
        check("rmid.acc", 32'(acc), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        for (int k = 0; k < 3; k++) run_instr($sformatf("rmid.re%0d", k));
        check("rmid.after", 32'(dut.memory_inst.mem[8'h40]), 32'h77);
        check_mem("rmid");

        // Wrap through 0xFE/0xFF and an unknown opcode at 0x00
        fill_bg();
        m_mem[0] = 8'hE5; m_mem[2] = 8'h09; m_mem[3] = 8'hFE;
        m_mem[8'hFE] = 8'h08; m_mem[8'hFF] = 8'h2A;
        for (int i = 4; i < 254; i += 2) m_mem[i] = 8'h00;
        prepare();
        for (int k = 0; k < 2; k++) run_instr($sformatf("wrap.pre%0d", k));
        check("wrap.jmp", 32'(pc), 32'hFE);
        run_instr("wrap.ldi");
        check("wrap.acc", 32'(acc), 32'h2A);
        check("wrap.pc0", 32'(pc), 32'h00);
        run_instr("wrap.unk");
        check("wrap.pc2", 32'(pc), 32'h02);
        check("wrap.acc2", 32'(acc), 32'h2A);

        // Instruction at 0xFF takes its operand from 0x00
        fill_bg();
        m_mem[0] = 8'h09; m_mem[1] = 8'hFF; m_mem[8'hFF] = 8'h08; m_mem[2] = 8'hFF;
        prepare();
        run_instr("odd.jmp");
        run_instr("odd.ldi");
        check("odd.acc", 32'(acc), 32'h09);
        check("odd.pc", 32'(pc), 32'h01);

        // Random programs against the model
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < 256; i++) begin
                if (i % 2 == 0) begin
                    r = int'($urandom_range(0, 15));
                    m_mem[i] = (r >= 12 && r <= 14) ? 8'($urandom) : 8'(r);
                end else begin
                    m_mem[i] = 8'($urandom);
                end
            end
            prepare();
            for (int k = 0; k < 40; k++) run_instr($sformatf("rnd%0d.i%0d", t, k));
            check_mem($sformatf("rnd%0d", t));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
